// File: rtl/irq_stim_pkg.sv
// Shared encodings for the interrupt stimulus generator: trigger modes,
// channel FSM states, register offsets and CTRL field positions.
package irq_stim_pkg;

  localparam logic [1:0] MODE_OFF      = 2'd0;
  localparam logic [1:0] MODE_DELAY    = 2'd1;
  localparam logic [1:0] MODE_ADDR     = 2'd2;
  localparam logic [1:0] MODE_PERIODIC = 2'd3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_FIRE     = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TARGET = 2'd1;
  localparam logic [1:0] REG_WIDTH  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned CTRL_MODE_LSB  = 0;
  localparam int unsigned CTRL_LEVEL_BIT = 2;

  function automatic logic st_is_busy(input logic [2:0] st);
    return (st == ST_ARMED) || (st == ST_FIRE) || (st == ST_WAIT_ACK);
  endfunction

endpackage

// File: rtl/irq_stim_channel.sv
// One interrupt channel: config registers, trigger/width counters and the
// IDLE/ARMED/FIRE/WAIT_ACK/DONE state machine.
module irq_stim_channel
  import irq_stim_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int PW_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [1:0]        i_reg,
  input  logic [ADDR_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_ack,
  output logic              o_irq,
  output logic              o_irq_nxt,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_MAX  = {ADDR_W{1'b1}};
  localparam logic [PW_W-1:0]   P_ZERO = {PW_W{1'b0}};
  localparam logic [PW_W-1:0]   P_ONE  = {{(PW_W-1){1'b0}}, 1'b1};
  localparam logic [PW_W-1:0]   P_MAX  = {PW_W{1'b1}};

  logic [2:0]        r_state, w_state_nxt;
  logic [1:0]        r_mode;
  logic              r_level;
  logic [ADDR_W-1:0] r_target, r_cnt, w_cnt_nxt, w_tgt_m1, w_cnt_inc;
  logic [PW_W-1:0]   r_width, r_wcnt, w_wcnt_nxt, w_wid_max, w_wcnt_inc;
  logic              r_match, r_irq, w_irq_nxt, r_busy;
  logic              w_ctrl_we, w_hold, w_trig, w_done;

  // Any valid write to this channel pre-empts a trigger or ack in the same cycle.
  assign w_ctrl_we  = i_we && (i_reg == REG_CTRL);
  assign w_hold     = i_we && (i_reg != REG_RSVD);
  assign w_tgt_m1   = (r_target == A_ZERO) ? A_ZERO : (r_target - A_ONE);
  assign w_wid_max  = (r_width == P_ZERO) ? P_ONE : r_width;
  assign w_cnt_inc  = (r_cnt == A_MAX) ? r_cnt : (r_cnt + A_ONE);
  assign w_wcnt_inc = (r_wcnt == P_MAX) ? r_wcnt : (r_wcnt + P_ONE);

  assign w_trig = !w_hold && (r_state == ST_ARMED) &&
                  ((r_mode == MODE_ADDR) ? r_match : (r_cnt >= w_tgt_m1));
  assign w_done = !w_hold &&
                  (((r_state == ST_FIRE) && !r_level && (r_wcnt >= w_wid_max)) ||
                   ((r_state == ST_WAIT_ACK) && i_ack));

  // Next-state, counter and interrupt-line logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wcnt_nxt  = r_wcnt;
    w_irq_nxt   = r_irq;
    if (w_ctrl_we) begin
      w_cnt_nxt  = A_ZERO;
      w_wcnt_nxt = P_ZERO;
      w_irq_nxt  = 1'b0;
      if (i_data[CTRL_MODE_LSB +: 2] != MODE_OFF) begin
        w_state_nxt = ST_ARMED;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (w_trig) begin
      w_state_nxt = ST_FIRE;
      w_irq_nxt   = 1'b1;
      w_wcnt_nxt  = P_ONE;
    end else if (w_done) begin
      w_irq_nxt = 1'b0;
      w_cnt_nxt = A_ZERO;
      if (r_mode == MODE_PERIODIC) begin
        w_state_nxt = ST_ARMED;
      end else begin
        w_state_nxt = ST_DONE;
      end
    end else begin
      case (r_state)
        ST_ARMED:    w_cnt_nxt = w_cnt_inc;
        ST_FIRE: begin
          if (r_level) begin
            w_state_nxt = ST_WAIT_ACK;
          end else begin
            w_wcnt_nxt = w_wcnt_inc;
          end
        end
        ST_IDLE, ST_WAIT_ACK, ST_DONE: w_state_nxt = r_state;
        default: begin
          w_state_nxt = ST_IDLE;
          w_irq_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_OFF;
      r_level  <= 1'b0;
      r_target <= A_ZERO;
      r_width  <= P_ZERO;
    end else if (i_we) begin
      case (i_reg)
        REG_CTRL: begin
          r_mode  <= i_data[CTRL_MODE_LSB +: 2];
          r_level <= i_data[CTRL_LEVEL_BIT];
        end
        REG_TARGET: r_target <= i_data;
        REG_WIDTH:  r_width  <= i_data[PW_W-1:0];
        default:    r_width  <= r_width;
      endcase
    end
  end

  // FSM state, counters, address-match flag and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= A_ZERO;
      r_wcnt  <= P_ZERO;
      r_match <= 1'b0;
      r_irq   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_match <= (r_state == ST_ARMED) && !w_ctrl_we && (i_pc == r_target);
      r_irq   <= w_irq_nxt;
      r_busy  <= st_is_busy(w_state_nxt);
    end
  end

  assign o_irq     = r_irq;
  assign o_irq_nxt = w_irq_nxt;
  assign o_busy    = r_busy;

endmodule

// File: rtl/irq_stim_gen.sv
// Multi-channel interrupt stimulus generator: config address decode, one
// channel per interrupt line, and the registered any-interrupt summary.
module irq_stim_gen
  import irq_stim_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 32,
  parameter int PW_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         pc_i,
  input  logic                      cfg_we_i,
  input  logic [$clog2(N_CH)+1:0]   cfg_a_i,
  input  logic [ADDR_W-1:0]         cfg_d_i,
  input  logic [N_CH-1:0]           ack_i,
  output logic [N_CH-1:0]           irq_o,
  output logic                      irq_any_o,
  output logic [N_CH-1:0]           busy_o
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0] w_ch;
  logic [1:0]      w_reg;
  logic [N_CH-1:0] w_we, w_irq, w_irq_nxt, w_busy;
  logic            r_any;

  assign w_reg = cfg_a_i[1:0];

  // Channel indices at or above N_CH decode to no channel.
  if (N_CH > 1) begin : g_ch_idx
    assign w_ch = cfg_a_i[$clog2(N_CH)+1:2];
  end else begin : g_ch_one
    assign w_ch = 1'b0;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_we[i] = cfg_we_i && (w_ch == CH_W'(i));

    irq_stim_channel #(
      .ADDR_W (ADDR_W),
      .PW_W   (PW_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_we      (w_we[i]),
      .i_reg     (w_reg),
      .i_data    (cfg_d_i),
      .i_pc      (pc_i),
      .i_ack     (ack_i[i]),
      .o_irq     (w_irq[i]),
      .o_irq_nxt (w_irq_nxt[i]),
      .o_busy    (w_busy[i])
    );
  end

  // Summary line follows the channels' next-state irq so it lines up with irq_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_irq_nxt;
    end
  end

  assign irq_o     = w_irq;
  assign irq_any_o = r_any;
  assign busy_o    = w_busy;

endmodule
